// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared definitions for the mul/div dispatch front end: function codes,
// FSM state encoding and small fn-decode helpers.
package imuldiv_muldiv_dispatch_pkg;

  // muldivreq function codes; codes above FN_REMU are undefined
  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // True for codes that map onto one of the two units
  function automatic logic fn_is_legal(input logic [2:0] fn);
    return (fn <= FN_REMU);
  endfunction

  // Remainder ops return the upper word of the divider result
  function automatic logic fn_is_rem(input logic [2:0] fn);
    return (fn == FN_REM) || (fn == FN_REMU);
  endfunction

  // Signed divider ops (DIV, REM)
  function automatic logic fn_is_signed_div(input logic [2:0] fn);
    return (fn == FN_DIV) || (fn == FN_REM);
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch.sv
// Front end of the iterative mul/div unit. Accepts one request, forwards the
// latched operands to the multiplier or divider, captures the 64-bit unit
// response and holds it until upstream takes it. One transaction in flight.
module imuldiv_muldiv_dispatch
  import imuldiv_muldiv_dispatch_pkg::*;
#(
  parameter logic [63:0] ILLEGAL_RESULT = 64'd0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,

  output logic [63:0] muldivresp_msg_result,
  output logic [31:0] muldivresp_msg_word,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,

  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,

  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy
);

  state_t      state_reg;
  logic [2:0]  fn_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [63:0] result_reg;
  logic        is_mul_reg;

  // Selected unit's handshake inputs, muxed on the registered target bit
  logic        unit_req_rdy;
  logic        unit_resp_val;
  logic [63:0] unit_resp_result;

  assign unit_req_rdy     = is_mul_reg ? mulreq_rdy         : divreq_rdy;
  assign unit_resp_val    = is_mul_reg ? mulresp_val        : divresp_val;
  assign unit_resp_result = is_mul_reg ? mulresp_msg_result : divresp_msg_result;

  // FSM plus operand latch and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      fn_reg     <= 3'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      result_reg <= 64'd0;
      is_mul_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (muldivreq_val) begin
            fn_reg     <= muldivreq_msg_fn;
            a_reg      <= muldivreq_msg_a;
            b_reg      <= muldivreq_msg_b;
            is_mul_reg <= (muldivreq_msg_fn == FN_MUL);
            if (fn_is_legal(muldivreq_msg_fn)) begin
              state_reg <= ST_ISSUE;
            end else begin
              // Undefined op: answer directly without touching either unit
              result_reg <= ILLEGAL_RESULT;
              state_reg  <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (unit_req_rdy) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (unit_resp_val) begin
            result_reg <= unit_resp_result;
            state_reg  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (muldivresp_rdy) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode only registered state, so none depend on inputs
  always_comb begin
    muldivreq_rdy  = (state_reg == ST_IDLE);
    muldivresp_val = (state_reg == ST_RESP);
    mulreq_val     = (state_reg == ST_ISSUE) &&  is_mul_reg;
    divreq_val     = (state_reg == ST_ISSUE) && !is_mul_reg;
    mulresp_rdy    = (state_reg == ST_WAIT)  &&  is_mul_reg;
    divresp_rdy    = (state_reg == ST_WAIT)  && !is_mul_reg;
  end

  // Operands go straight from the latch; sign handling belongs to the units
  assign mulreq_msg_a  = a_reg;
  assign mulreq_msg_b  = b_reg;
  assign divreq_msg_a  = a_reg;
  assign divreq_msg_b  = b_reg;
  assign divreq_msg_fn = fn_is_signed_div(fn_reg);

  assign muldivresp_msg_result = result_reg;
  assign muldivresp_msg_word   = fn_is_rem(fn_reg) ? result_reg[63:32] : result_reg[31:0];

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Randomized self-checking bench for imuldiv_muldiv_dispatch. The bench plays
// both iterative units and upstream, and predicts results with plain arithmetic.
module tb_imuldiv_muldiv_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic [31:0] muldivresp_msg_word;
  logic        muldivresp_val, muldivresp_rdy;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val, mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val, mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divreq_val, divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val, divresp_rdy;

  int n_checks = 0;
  int n_errors = 0;

  imuldiv_muldiv_dispatch dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_msg_word(muldivresp_msg_word),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
    .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
    .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
    .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
    .divresp_rdy(divresp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // What the unit itself returns: signed product, or {rem, quot}
  function automatic logic [63:0] unit_model(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint prod;
    int     sq, sr;
    case (fn)
      3'd0: begin
        prod = longint'($signed(a)) * longint'($signed(b));
        return prod;
      end
      3'd1, 3'd3: begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {32'(sr), 32'(sq)};
      end
      3'd2, 3'd4: return {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  // The 32-bit answer the pipeline wants for each op
  function automatic logic [31:0] word_model(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    int sq, sr;
    case (fn)
      3'd0: return a * b;
      3'd1: begin sq = $signed(a) / $signed(b); return 32'(sq); end
      3'd2: return a / b;
      3'd3: begin sr = $signed(a) % $signed(b); return 32'(sr); end
      3'd4: return a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_issue(input bit is_mul, input logic [2:0] fn, input logic [31:0] a,
                             input logic [31:0] b);
    check("issue_val",    is_mul ? mulreq_val : divreq_val, 1);
    check("issue_other",  is_mul ? divreq_val : mulreq_val, 0);
    check("issue_a",      is_mul ? mulreq_msg_a : divreq_msg_a, a);
    check("issue_b",      is_mul ? mulreq_msg_b : divreq_msg_b, b);
    check("issue_reqrdy", muldivreq_rdy, 0);
    if (!is_mul) check("div_fn", divreq_msg_fn, (fn == 3'd1 || fn == 3'd3));
  endtask

  // One full transaction with chosen stall lengths
  task automatic run_txn(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input int issue_stall, input int unit_lat, input int resp_stall);
    logic [63:0] unit_res;
    logic [31:0] exp_word;
    bit          legal, is_mul;
    legal    = (fn <= 3'd4);
    is_mul   = (fn == 3'd0);
    unit_res = unit_model(fn, a, b);
    exp_word = word_model(fn, a, b);
    $display("txn fn=%0d a=%h b=%h stalls=%0d/%0d/%0d exp=%h word=%h",
             fn, a, b, issue_stall, unit_lat, resp_stall, unit_res, exp_word);

    check("accept_rdy", muldivreq_rdy, 1);
    muldivreq_val = 1'b1; muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
    cycle();
    // Scramble the request bus so the latch is what drives the units
    muldivreq_val = 1'b0; muldivreq_msg_fn = 3'($urandom);
    muldivreq_msg_a = $urandom; muldivreq_msg_b = $urandom;

    if (!legal) begin
      check("illegal_mulval", mulreq_val, 0);
      check("illegal_divval", divreq_val, 0);
    end else begin
      for (int i = 0; i < issue_stall; i++) begin
        check_issue(is_mul, fn, a, b);
        // Responses outside WAIT must be ignored
        mulresp_val = 1'b1; mulresp_msg_result = {$urandom, $urandom};
        divresp_val = 1'b1; divresp_msg_result = {$urandom, $urandom};
        check("issue_mulresp_rdy", mulresp_rdy, 0);
        check("issue_divresp_rdy", divresp_rdy, 0);
        cycle();
        mulresp_val = 1'b0; divresp_val = 1'b0;
      end
      check_issue(is_mul, fn, a, b);
      if (is_mul) mulreq_rdy = 1'b1; else divreq_rdy = 1'b1;
      cycle();
      mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
      for (int i = 0; i <= unit_lat; i++) begin
        check("wait_reqval", mulreq_val | divreq_val, 0);
        check("wait_respval", muldivresp_val, 0);
        check("wait_sel_rdy",   is_mul ? mulresp_rdy : divresp_rdy, 1);
        check("wait_other_rdy", is_mul ? divresp_rdy : mulresp_rdy, 0);
        if (i == unit_lat) begin
          if (is_mul) begin mulresp_val = 1'b1; mulresp_msg_result = unit_res; end
          else        begin divresp_val = 1'b1; divresp_msg_result = unit_res; end
        end else begin
          // Unselected unit chatters; must not be captured
          if (is_mul) begin divresp_val = 1'b1; divresp_msg_result = {$urandom, $urandom}; end
          else        begin mulresp_val = 1'b1; mulresp_msg_result = {$urandom, $urandom}; end
        end
        cycle();
        mulresp_val = 1'b0; divresp_val = 1'b0;
      end
    end

    for (int i = 0; i <= resp_stall; i++) begin
      check("resp_val",    muldivresp_val, 1);
      check("resp_result", muldivresp_msg_result, unit_res);
      check("resp_word",   muldivresp_msg_word, exp_word);
      check("resp_reqrdy", muldivreq_rdy, 0);
      check("resp_unitval", mulreq_val | divreq_val, 0);
      if (i == resp_stall) muldivresp_rdy = 1'b1;
      cycle();
      muldivresp_rdy = 1'b0;
    end
    check("done_respval", muldivresp_val, 0);
    check("done_reqrdy",  muldivreq_rdy, 1);
  endtask

  initial begin
    logic [2:0]  fn;
    logic [31:0] a, b;
    reset = 1'b1;
    muldivreq_val = 0; muldivreq_msg_fn = 0; muldivreq_msg_a = 0; muldivreq_msg_b = 0;
    muldivresp_rdy = 0; mulreq_rdy = 0; divreq_rdy = 0;
    mulresp_val = 0; mulresp_msg_result = 0; divresp_val = 0; divresp_msg_result = 0;
    @(negedge clk);
    cycle();
    check("rst_reqrdy",  muldivreq_rdy, 1);
    check("rst_respval", muldivresp_val, 0);
    check("rst_unitval", {mulreq_val, divreq_val, mulresp_rdy, divresp_rdy}, 0);
    check("rst_result",  muldivresp_msg_result, 0);
    check("rst_word",    muldivresp_msg_word, 0);
    reset = 1'b0;

    // Directed cases
    run_txn(3'd0, 32'd7, 32'hFFFFFFFD, 0, 0, 0);
    check("mul_neg21", muldivresp_msg_result, 64'hFFFFFFFFFFFFFFEB);
    run_txn(3'd1, 32'hFFFFFFF9, 32'd2, 0, 1, 0);
    run_txn(3'd4, 32'd17, 32'd5, 0, 2, 0);
    run_txn(3'd6, 32'd123, 32'd456, 0, 0, 0);
    run_txn(3'd2, 32'd1000, 32'd7, 4, 0, 5);

    // Reset while waiting on the divider, with a response on the same edge
    $display("txn reset-in-WAIT DIVU");
    muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd2; muldivreq_msg_a = 32'd50; muldivreq_msg_b = 32'd3;
    cycle();
    muldivreq_val = 1'b0;
    divreq_rdy = 1'b1;
    cycle();
    divreq_rdy = 1'b0;
    check("rw_in_wait", divresp_rdy, 1);
    reset = 1'b1; divresp_val = 1'b1; divresp_msg_result = 64'h0000_0002_0000_0010;
    cycle();
    reset = 1'b0; divresp_val = 1'b0;
    check("rw_respval", muldivresp_val, 0);
    check("rw_reqrdy",  muldivreq_rdy, 1);
    check("rw_result",  muldivresp_msg_result, 0);
    check("rw_divrdy",  divresp_rdy, 0);
    run_txn(3'd3, 32'hFFFFFFEF, 32'd5, 1, 1, 1);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      fn = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 20)) - 10) : $urandom;
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      run_txn(fn, a, b, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
